// File: rtl/tick_pkg.sv
// Shared types and reset-default configuration for the tick sequencer.
// State encoding puts busy in bit 0 and paused in bit 1, so both flags decode straight from the state register.
package tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b11
    } state_t;

    localparam int DEF_DIV   = 11;
    localparam int DEF_TICKS = 0;

endpackage

// File: rtl/tick_prescaler.sv
// N-bit enabled counter with synchronous clear and a run-time terminal compare.
// The terminal flag is combinational so the FSM can act on it in the same cycle.
module tick_prescaler #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] limit,
    output logic         term
);

    logic [N-1:0] pre_q, pre_d;

    // limit is never 0, so limit-1 cannot underflow
    assign term = (pre_q == limit - N'(1));

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = term ? '0 : pre_q + N'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre_q <= '0;
        else        pre_q <= pre_d;
    end

endmodule

// File: rtl/tick_sequencer.sv
// Programmable tick-train controller: registered divisor and burst length,
// start/pause/resume/abort control, one-cycle tick and done pulses.
module tick_sequencer #(
    parameter int N         = 8,
    parameter int M         = 8,
    parameter int DEF_DIV   = tick_pkg::DEF_DIV,
    parameter int DEF_TICKS = tick_pkg::DEF_TICKS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [N-1:0] cfg_div,
    input  logic [M-1:0] cfg_ticks,
    input  logic         start,
    input  logic         pause,
    input  logic         resume,
    input  logic         abort,
    output logic         tick,
    output logic         done,
    output logic         busy,
    output logic         paused,
    output logic [M-1:0] ticks_left,
    output logic         cfg_err
);
    import tick_pkg::*;

    state_t       state_q, state_d;
    logic [N-1:0] div_q, div_d;
    logic [M-1:0] tks_q, tks_d;
    logic [M-1:0] left_q, left_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         cfg_ok;
    logic         pre_en, pre_clr, pre_term;

    tick_prescaler #(.N(N)) u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .limit (div_q),
        .term  (pre_term)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tks_d   = tks_q;
        left_d  = left_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        pre_en  = 1'b0;
        pre_clr = 1'b0;
        cfg_ok  = cfg_we && (state_q == IDLE) && (cfg_div != '0);

        if (cfg_we) begin
            if (cfg_ok) begin
                div_d = cfg_div;
                tks_d = cfg_ticks;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                // a configuration write in the same cycle takes precedence over start
                if (start && !cfg_we) begin
                    state_d = RUN;
                    pre_clr = 1'b1;
                    left_d  = tks_q;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    pre_clr = 1'b1;
                    left_d  = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    pre_en = 1'b1;
                    if (pre_term) begin
                        tick_d = 1'b1;
                        // ticks_left is zero only in continuous mode
                        if (left_q != '0) begin
                            left_d = left_q - M'(1);
                            if (left_q == M'(1)) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                    pre_clr = 1'b1;
                    left_d  = '0;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= N'(DEF_DIV);
            tks_q   <= M'(DEF_TICKS);
            left_q  <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tks_q   <= tks_d;
            left_q  <= left_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tick       = tick_q;
    assign done       = done_q;
    assign busy       = state_q[0];
    assign paused     = state_q[1];
    assign ticks_left = left_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: vector table, directed corner sequences and
// randomized control traffic checked against a countdown-based reference model.
module tb_tick_sequencer;

    localparam int N    = 8;
    localparam int M    = 8;
    localparam int DDIV = 11;
    localparam int DTKS = 0;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cfg_we = 1'b0;
    logic [N-1:0] cfg_div = '0;
    logic [M-1:0] cfg_ticks = '0;
    logic         start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0;
    logic         tick, done, busy, paused, cfg_err;
    logic [M-1:0] ticks_left;

    always #5 clk = ~clk;

    tick_sequencer #(.N(N), .M(M), .DEF_DIV(DDIV), .DEF_TICKS(DTKS)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_div(cfg_div),
        .cfg_ticks(cfg_ticks), .start(start), .pause(pause), .resume(resume),
        .abort(abort), .tick(tick), .done(done), .busy(busy), .paused(paused),
        .ticks_left(ticks_left), .cfg_err(cfg_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 paused; m_wait counts the
    // running edges still needed before the next tick.
    int m_mode, m_div, m_tks, m_left, m_wait;
    bit m_tick, m_done, m_err;

    task automatic model_reset();
        m_mode = 0; m_div = DDIV; m_tks = DTKS; m_left = 0; m_wait = 0;
        m_tick = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        m_tick = 0;
        m_done = 0;
        if (cfg_we) begin
            if (m_mode == 0 && cfg_div != 0) begin
                m_div = int'(cfg_div); m_tks = int'(cfg_ticks); m_err = 0;
            end else begin
                m_err = 1;
            end
        end
        case (m_mode)
            0: if (start && !cfg_we) begin
                m_mode = 1; m_left = m_tks; m_wait = m_div;
            end
            1: begin
                if (abort) begin
                    m_mode = 0; m_left = 0;
                end else if (pause) begin
                    m_mode = 2;
                end else begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_tick = 1;
                        m_wait = m_div;
                        if (m_left > 0) begin
                            m_left--;
                            if (m_left == 0) begin
                                m_done = 1; m_mode = 0;
                            end
                        end
                    end
                end
            end
            default: begin
                if (abort) begin
                    m_mode = 0; m_left = 0;
                end else if (resume) begin
                    m_mode = 1;
                end
            end
        endcase
    endtask

    task automatic clear_inputs();
        cfg_we = 0; start = 0; pause = 0; resume = 0; abort = 0;
    endtask

    task automatic step(input string name);
        logic [12:0] got, exp;
        @(posedge clk); #1;
        model_step();
        got = {tick, done, busy, paused, ticks_left, cfg_err};
        exp = {m_tick, m_done, m_mode != 0, m_mode == 2, M'(m_left), m_err};
        chk(name, 32'(got), 32'(exp));
    endtask

    task automatic cyc(input bit we, input int d, input int t,
                       input bit s, input bit p, input bit r, input bit a, input string name);
        cfg_we = we; cfg_div = N'(d); cfg_ticks = M'(t);
        start = s; pause = p; resume = r; abort = a;
        step(name);
        clear_inputs();
    endtask

    task automatic idle_cyc(input int n, input string name);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        chk("reset_state", 32'({tick, done, busy, paused, ticks_left, cfg_err}), 32'(0));
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  d, t;
        logic        s, p, r, a;
        logic [12:0] exp;
    } vec_t;

    function automatic vec_t v(input logic we, input int d, input int t,
                               input logic s, input logic p, input logic r, input logic a,
                               input logic tk, input logic dn, input logic bz, input logic pz,
                               input int lf, input logic er);
        vec_t x;
        x.we = we; x.d = 8'(d); x.t = 8'(t);
        x.s = s; x.p = p; x.r = r; x.a = a;
        x.exp = {tk, dn, bz, pz, 8'(lf), er};
        return x;
    endfunction

    vec_t tbl[$];

    initial begin
        int n, cnt;

        // div=4, ticks=3 burst, then rejected writes and a div=2 single-tick burst
        tbl.push_back(v(1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 3, 1));
        tbl.push_back(v(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            cfg_we = tbl[i].we; cfg_div = tbl[i].d; cfg_ticks = tbl[i].t;
            start = tbl[i].s; pause = tbl[i].p; resume = tbl[i].r; abort = tbl[i].a;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i),
                32'({tick, done, busy, paused, ticks_left, cfg_err}), 32'(tbl[i].exp));
            clear_inputs();
        end

        // div=1 continuous: a tick on every running cycle, then abort
        do_reset();
        cyc(1, 1, 0, 0, 0, 0, 0, "d1_cfg");
        cyc(0, 0, 0, 1, 0, 0, 0, "d1_start");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, "d1_run");
            if (tick) cnt++;
        end
        chk("d1_tick_count", 32'(cnt), 32'd20);
        cyc(0, 0, 0, 0, 0, 0, 1, "d1_abort");
        chk("d1_after_abort", 32'({busy, done, ticks_left}), 32'd0);

        // div=5, ticks=2: pause at cycle 3 for 10 cycles, then resume
        cyc(1, 5, 2, 0, 0, 0, 0, "p_cfg");
        cyc(0, 0, 0, 1, 0, 0, 0, "p_start");
        idle_cyc(2, "p_run");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, "p_hold");
            if (tick) cnt++;
        end
        chk("p_no_tick_paused", 32'(cnt), 32'd0);
        chk("p_left_held", 32'(ticks_left), 32'd2);
        cyc(0, 0, 0, 0, 0, 1, 0, "p_resume");
        n = 0;
        do begin
            cyc(0, 0, 0, 0, 0, 0, 0, "p_wait");
            n++;
        end while (!tick && n < 20);
        chk("p_first_tick_after_resume", 32'(n), 32'd3);
        idle_cyc(6, "p_finish");
        chk("p_burst_done", 32'({busy, ticks_left}), 32'd0);

        // pause landing exactly on the terminal cycle, div=3
        cyc(1, 3, 0, 0, 0, 0, 0, "t_cfg");
        cyc(0, 0, 0, 1, 0, 0, 0, "t_start");
        idle_cyc(2, "t_run");
        cyc(0, 0, 0, 0, 1, 0, 0, "t_pause");
        chk("t_no_tick_on_pause", 32'(tick), 32'd0);
        idle_cyc(3, "t_paused");
        cyc(0, 0, 0, 0, 0, 1, 0, "t_resume");
        chk("t_no_tick_on_resume", 32'(tick), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, "t_first_run");
        chk("t_tick_after_resume", 32'(tick), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, "t_abort");

        // async reset between edges while ticking every cycle
        cyc(1, 1, 0, 0, 0, 0, 0, "r_cfg");
        cyc(0, 0, 0, 1, 0, 0, 0, "r_start");
        idle_cyc(3, "r_run");
        #3 reset = 0;
        #1 chk("r_async_clear", 32'({tick, done, busy}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1;

        // rejected writes leave the default divisor in place
        cyc(1, 0, 3, 0, 0, 0, 0, "e_div0");
        chk("e_err_idle", 32'(cfg_err), 32'd1);
        cyc(0, 0, 0, 1, 0, 0, 0, "e_start");
        n = 0;
        do begin
            cyc(n == 3, 6, 1, 0, 0, 0, 0, "e_wait1");
            n++;
        end while (!tick && n < 40);
        chk("e_first_period", 32'(n), 32'(DDIV));
        chk("e_err_run", 32'(cfg_err), 32'd1);
        n = 0;
        do begin
            cyc(0, 0, 0, 0, 0, 0, 0, "e_wait2");
            n++;
        end while (!tick && n < 40);
        chk("e_second_period", 32'(n), 32'(DDIV));
        cyc(0, 0, 0, 0, 0, 0, 1, "e_abort");
        cyc(1, 2, 0, 0, 0, 0, 0, "e_valid");
        chk("e_err_cleared", 32'(cfg_err), 32'd0);

        // randomized control traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cfg_we    = ($urandom_range(99) < 6);
            cfg_div   = N'($urandom_range(6));
            cfg_ticks = M'($urandom_range(4));
            start     = !cfg_we && ($urandom_range(99) < 25);
            pause     = ($urandom_range(99) < 8);
            resume    = ($urandom_range(99) < 20);
            abort     = ($urandom_range(99) < 3);
            step("rand");
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
